// File: rtl/int_pkg.sv
// Shared types and helpers for the serial integer reducer: FSM state encoding
// and the adder-node latency calculation.
package int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Pipeline depth of the adder node for a given register configuration.
    function automatic int adder_latency(input int reg_middle, input int reg_output);
        return ((reg_middle != 32'sd0) ? 32'sd1 : 32'sd0) +
               ((reg_output != 32'sd0) ? 32'sd1 : 32'sd0);
    endfunction

endpackage

// File: rtl/int_adder_tree_node.sv
// Two-operand adder with optional split-carry middle register and optional
// output register; contents carry no validity, the caller tracks latency.
module int_adder_tree_node #(
    parameter int IN_BITS         = 16,
    parameter int OUT_BITS        = 17,
    parameter int SIGN_EXT        = 1,
    parameter int REGISTER_MIDDLE = 0,
    parameter int REGISTER_OUTPUT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_BITS-1:0]  a,
    input  logic [IN_BITS-1:0]  b,
    output logic [OUT_BITS-1:0] sum
);
    localparam int LO = OUT_BITS / 2;
    localparam int HI = OUT_BITS - LO;

    logic [OUT_BITS-1:0] a_ext_s, b_ext_s, full_s;
    logic [LO:0]         lo_sum_s, mid_lo_s;
    logic [HI-1:0]       mid_a_hi_s, mid_b_hi_s, hi_sum_s;

    assign a_ext_s  = {{(OUT_BITS-IN_BITS){a[IN_BITS-1] & (SIGN_EXT != 0)}}, a};
    assign b_ext_s  = {{(OUT_BITS-IN_BITS){b[IN_BITS-1] & (SIGN_EXT != 0)}}, b};
    assign lo_sum_s = {1'b0, a_ext_s[LO-1:0]} + {1'b0, b_ext_s[LO-1:0]};

    // The low half and its carry are cut here; the high half finishes next cycle.
    if (REGISTER_MIDDLE != 0) begin : g_mid
        logic [LO:0]   lo_r;
        logic [HI-1:0] a_hi_r, b_hi_r;
        // Middle pipeline stage: low partial sum plus unconsumed high operands.
        always_ff @(posedge clk) begin
            if (rst) begin
                lo_r   <= '0;
                a_hi_r <= '0;
                b_hi_r <= '0;
            end else begin
                lo_r   <= lo_sum_s;
                a_hi_r <= a_ext_s[OUT_BITS-1:LO];
                b_hi_r <= b_ext_s[OUT_BITS-1:LO];
            end
        end
        assign mid_lo_s   = lo_r;
        assign mid_a_hi_s = a_hi_r;
        assign mid_b_hi_s = b_hi_r;
    end else begin : g_nomid
        assign mid_lo_s   = lo_sum_s;
        assign mid_a_hi_s = a_ext_s[OUT_BITS-1:LO];
        assign mid_b_hi_s = b_ext_s[OUT_BITS-1:LO];
    end

    assign hi_sum_s = mid_a_hi_s + mid_b_hi_s + {{(HI-1){1'b0}}, mid_lo_s[LO]};
    assign full_s   = {hi_sum_s, mid_lo_s[LO-1:0]};

    if (REGISTER_OUTPUT != 0) begin : g_out
        logic [OUT_BITS-1:0] sum_r;
        // Output pipeline stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_r <= '0;
            end else begin
                sum_r <= full_s;
            end
        end
        assign sum = sum_r;
    end else begin : g_noout
        assign sum = full_s;
    end

endmodule

// File: rtl/int_serial_reducer.sv
// Serial signed-sum reducer: accumulates beats through a pipelined adder node
// until in_last, then presents the sum, beat count and overflow flag.
module int_serial_reducer
    import int_pkg::*;
#(
    parameter int IN_BITS         = 16,
    parameter int MAX_LEN         = 64,
    parameter int ACC_BITS        = IN_BITS + $clog2(MAX_LEN),
    parameter int REGISTER_MIDDLE = 0,
    parameter int REGISTER_OUTPUT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IN_BITS-1:0]  in_data,
    input  logic                       in_last,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [ACC_BITS-1:0] out_data,
    output logic [$clog2(MAX_LEN):0]   out_len,
    output logic                       out_ovf,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int LAT    = adder_latency(REGISTER_MIDDLE, REGISTER_OUTPUT);
    localparam int CNT_W  = $clog2(MAX_LEN) + 1;
    localparam int WAIT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    state_e              state_r, state_next_s;
    logic [ACC_BITS-1:0] acc_r, acc_next_s, in_ext_s, sum_trunc_s;
    logic [ACC_BITS:0]   sum_s;
    logic [CNT_W-1:0]    count_r, count_next_s, count_inc_s, out_len_r, out_len_next_s;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_next_s;
    logic [ACC_BITS-1:0] out_data_r, out_data_next_s;
    logic                last_r, last_next_s, in_ready_r, in_ready_next_s;
    logic                out_valid_r, out_valid_next_s, out_ovf_r, out_ovf_next_s;
    logic                accept_s, ovf_inc_s, unused_msb_s;

    assign in_ext_s     = {{(ACC_BITS-IN_BITS){in_data[IN_BITS-1]}}, in_data};
    assign accept_s     = in_valid && in_ready_r;
    assign count_inc_s  = (count_r == CNT_W'(MAX_LEN + 1)) ? count_r : count_r + CNT_W'(1);
    assign ovf_inc_s    = count_inc_s > CNT_W'(MAX_LEN);
    assign sum_trunc_s  = sum_s[ACC_BITS-1:0];
    assign unused_msb_s = sum_s[ACC_BITS];

    int_adder_tree_node #(
        .IN_BITS        (ACC_BITS),
        .OUT_BITS       (ACC_BITS + 1),
        .SIGN_EXT       (1),
        .REGISTER_MIDDLE(REGISTER_MIDDLE),
        .REGISTER_OUTPUT(REGISTER_OUTPUT)
    ) u_adder (
        .clk(clk),
        .rst(~rst_n),
        .a  (acc_r),
        .b  (in_ext_s),
        .sum(sum_s)
    );

    // Next-state and datapath update; adder operands are only meaningful on the accept cycle.
    always_comb begin
        state_next_s     = state_r;
        acc_next_s       = acc_r;
        count_next_s     = count_r;
        wait_next_s      = wait_cnt_r;
        last_next_s      = last_r;
        out_valid_next_s = out_valid_r;
        out_data_next_s  = out_data_r;
        out_len_next_s   = out_len_r;
        out_ovf_next_s   = out_ovf_r;
        case (state_r)
            ST_IDLE, ST_ACCUM: begin
                if (accept_s) begin
                    count_next_s = count_inc_s;
                    last_next_s  = in_last;
                    if (LAT == 0) begin
                        acc_next_s = sum_trunc_s;
                        if (in_last) begin
                            state_next_s     = ST_DONE;
                            out_valid_next_s = 1'b1;
                            out_data_next_s  = sum_trunc_s;
                            out_len_next_s   = count_inc_s;
                            out_ovf_next_s   = ovf_inc_s;
                        end else begin
                            state_next_s = ST_ACCUM;
                        end
                    end else begin
                        state_next_s = ST_WAIT;
                        wait_next_s  = WAIT_W'(LAT);
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_W'(1)) begin
                    acc_next_s = sum_trunc_s;
                    if (last_r) begin
                        state_next_s     = ST_DONE;
                        out_valid_next_s = 1'b1;
                        out_data_next_s  = sum_trunc_s;
                        out_len_next_s   = count_r;
                        out_ovf_next_s   = count_r > CNT_W'(MAX_LEN);
                    end else begin
                        state_next_s = ST_ACCUM;
                    end
                end else begin
                    wait_next_s = wait_cnt_r - WAIT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s     = ST_IDLE;
                    acc_next_s       = '0;
                    count_next_s     = '0;
                    out_valid_next_s = 1'b0;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        in_ready_next_s = (state_next_s == ST_IDLE) || (state_next_s == ST_ACCUM);
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            count_r     <= '0;
            wait_cnt_r  <= '0;
            last_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_len_r   <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            acc_r       <= acc_next_s;
            count_r     <= count_next_s;
            wait_cnt_r  <= wait_next_s;
            last_r      <= last_next_s;
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
            out_data_r  <= out_data_next_s;
            out_len_r   <= out_len_next_s;
            out_ovf_r   <= out_ovf_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_len   = out_len_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_int_serial_reducer.sv
// Scoreboard bench for int_serial_reducer: three instances cover latency 1
// (defaults), latency 0, and latency 2 with MAX_LEN=4.
module tb_int_serial_reducer;

    typedef struct {
        int data;
        int len;
        int ovf;
    } exp_t;

    localparam int ACCW [3] = '{22, 22, 18};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [15:0] in_data [3];
    logic in_valid [3];
    logic in_last [3];
    logic out_ready [3];
    logic ovalid [3];
    logic oovf [3];
    logic iready [3];
    logic signed [21:0] a_od, b_od;
    logic signed [17:0] c_od;
    logic [6:0] a_ol, b_ol;
    logic [2:0] c_ol;
    int od [3];
    int ol [3];
    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;
    int acc_cnt [3] = '{0, 0, 0};
    bit rand_rdy = 1'b0;
    exp_t exp_q [3][$];

    always #5 clk = ~clk;

    assign od[0] = int'(a_od);
    assign od[1] = int'(b_od);
    assign od[2] = int'(c_od);
    assign ol[0] = int'(a_ol);
    assign ol[1] = int'(b_ol);
    assign ol[2] = int'(c_ol);

    int_serial_reducer u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_last(in_last[0]),
        .in_valid(in_valid[0]), .in_ready(iready[0]), .out_data(a_od), .out_len(a_ol),
        .out_ovf(oovf[0]), .out_valid(ovalid[0]), .out_ready(out_ready[0])
    );

    int_serial_reducer #(.REGISTER_OUTPUT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_last(in_last[1]),
        .in_valid(in_valid[1]), .in_ready(iready[1]), .out_data(b_od), .out_len(b_ol),
        .out_ovf(oovf[1]), .out_valid(ovalid[1]), .out_ready(out_ready[1])
    );

    int_serial_reducer #(.MAX_LEN(4), .REGISTER_MIDDLE(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_last(in_last[2]),
        .in_valid(in_valid[2]), .in_ready(iready[2]), .out_data(c_od), .out_len(c_ol),
        .out_ovf(oovf[2]), .out_valid(ovalid[2]), .out_ready(out_ready[2])
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sext_to(input int v, input int bits);
        int s;
        s = 32 - bits;
        return (v <<< s) >>> s;
    endfunction

    task automatic push_exp(input int k, input int sum, input int len, input int ovf);
        exp_t e;
        e.data = sext_to(sum, ACCW[k]);
        e.len  = len;
        e.ovf  = ovf;
        exp_q[k].push_back(e);
    endtask

    // Cycle counter and accept counter (acceptance decided by values seen before the edge).
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && in_valid[k] && iready[k]) acc_cnt[k] = acc_cnt[k] + 1;
        end
    end

    // Output monitor: every completed output handshake is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rst_n && ovalid[k] && out_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    check_eq($sformatf("unexpected_out[%0d]", k), 1, 0);
                end else begin
                    e = exp_q[k].pop_front();
                    check_eq($sformatf("out_data[%0d]", k), od[k], e.data);
                    check_eq($sformatf("out_len[%0d]", k), ol[k], e.len);
                    check_eq($sformatf("out_ovf[%0d]", k), oovf[k], e.ovf);
                end
            end
        end
    end

    task automatic drive_beat(input int k, input int d, input bit last);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        in_data[k]  = 16'(d);
        in_last[k]  = last;
        @(negedge clk);
        while (!iready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq($sformatf("accept_timeout[%0d]", k), n, 0);
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_data[k]  = 16'($urandom);
        in_last[k]  = 1'($urandom);
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while (exp_q[k].size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) check_eq($sformatf("drain_timeout[%0d]", k), n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a0, n, len, sum;
        logic signed [15:0] v;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_last[k] = 1'b0; in_data[k] = 16'sd0; out_ready[k] = 1'b1;
        end
        // Reset state.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_ready[%0d]", k), iready[k], 0);
            check_eq($sformatf("rst_valid[%0d]", k), ovalid[k], 0);
            check_eq($sformatf("rst_data[%0d]", k), od[k], 0);
            check_eq($sformatf("rst_len[%0d]", k), ol[k], 0);
            check_eq($sformatf("rst_ovf[%0d]", k), oovf[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) check_eq($sformatf("ready_after_rst[%0d]", k), iready[k], 1);

        // L=1: 3, -5, 7 -> 5, in_ready low for one cycle after each accept.
        drive_beat(0, 3, 1'b0);
        check_eq("l1_rdy_low_1", iready[0], 0);
        @(posedge clk); #1;
        check_eq("l1_rdy_back_1", iready[0], 1);
        drive_beat(0, -5, 1'b0);
        check_eq("l1_rdy_low_2", iready[0], 0);
        @(posedge clk); #1;
        check_eq("l1_rdy_back_2", iready[0], 1);
        push_exp(0, 5, 3, 0);
        drive_beat(0, 7, 1'b1);
        check_eq("l1_rdy_low_3", iready[0], 0);
        wait_drain(0);

        // L=0: four back-to-back beats of 32767, one accept per cycle.
        c0 = cyc;
        a0 = acc_cnt[1];
        push_exp(1, 131068, 4, 0);
        for (int i = 0; i < 4; i++) drive_beat(1, 32767, i == 3);
        check_eq("l0_cycles", cyc - c0, 4);
        check_eq("l0_accepts", acc_cnt[1] - a0, 4);
        wait_drain(1);

        // MAX_LEN=4: exactly four beats is not overflow; five beats is.
        push_exp(2, 4, 4, 0);
        for (int i = 0; i < 4; i++) drive_beat(2, 1, i == 3);
        wait_drain(2);
        push_exp(2, 5, 5, 1);
        for (int i = 0; i < 5; i++) drive_beat(2, 1, i == 4);
        wait_drain(2);

        // Backpressure: out_ready low for 10 cycles in DONE with junk offered on the input.
        out_ready[0] = 1'b0;
        push_exp(0, 300, 2, 0);
        drive_beat(0, 100, 1'b0);
        drive_beat(0, 200, 1'b1);
        n = 0;
        while (!ovalid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("done_timeout", n, 0);
        a0 = acc_cnt[0];
        in_valid[0] = 1'b1;
        in_last[0]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data[0] = 16'($urandom);
            @(negedge clk);
            check_eq("hold_valid", ovalid[0], 1);
            check_eq("hold_data", od[0], 300);
            check_eq("hold_len", ol[0], 2);
            check_eq("hold_ovf", oovf[0], 0);
            check_eq("hold_ready", iready[0], 0);
        end
        in_valid[0] = 1'b0;
        check_eq("hold_no_accept", acc_cnt[0] - a0, 0);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        wait_drain(0);

        // Reset after 2 of 4 beats discards the partial sum.
        drive_beat(0, 10, 1'b0);
        drive_beat(0, 20, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst_ready", iready[0], 0);
        check_eq("midrst_valid", ovalid[0], 0);
        check_eq("midrst_data", od[0], 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_ready_rise", iready[0], 1);
        repeat (20) @(posedge clk);
        #1;
        push_exp(0, -1, 1, 0);
        drive_beat(0, -1, 1'b1);
        wait_drain(0);

        // L=2: random lengths and gaps, random output backpressure.
        rand_rdy = 1'b1;
        fork
            begin
                while (rand_rdy) begin
                    @(posedge clk);
                    #1;
                    out_ready[2] = ($urandom_range(0, 2) != 0);
                end
            end
        join_none
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(1, 4);
            sum = 0;
            for (int i = 0; i < len; i++) begin
                v = 16'($urandom);
                sum += int'(v);
                if (i == len - 1) push_exp(2, sum, len, 0);
                n = $urandom_range(0, 3);
                repeat (n) @(posedge clk);
                #1;
                drive_beat(2, int'(v), i == len - 1);
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready[2] = 1'b1;
        wait_drain(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/int_serial_reducer.md
INT_SERIAL_REDUCER -- requirements
Module: int_serial_reducer

Interface
REQ-001 SHALL have parameter IN_BITS, default 16, width of signed input operands.
REQ-002 SHALL have parameter MAX_LEN, default 64, maximum beats per reduction.
REQ-003 SHALL have parameter ACC_BITS, default IN_BITS+$clog2(MAX_LEN), accumulator and result width.
REQ-004 SHALL have parameter REGISTER_MIDDLE, default 0, which enables the split-carry register inside the adder node.
REQ-005 SHALL have parameter REGISTER_OUTPUT, default 1, which enables the adder-node output register.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic SHALL be on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-008 SHALL have port in_data, input, IN_BITS, a signed operand.
REQ-009 SHALL have port in_last, input, 1, which marks the final beat of a reduction.
REQ-010 SHALL have port in_valid, input, 1, and port in_ready, output, 1, forming the input handshake.
REQ-011 SHALL have port out_data, output, ACC_BITS, the signed sum.
REQ-012 SHALL have port out_len, output, $clog2(MAX_LEN)+1, the number of beats summed.
REQ-013 SHALL have port out_ovf, output, 1, set when the beat count exceeded MAX_LEN.
REQ-014 SHALL have port out_valid, output, 1, and port out_ready, input, 1, forming the output handshake.

Function
REQ-015 SHALL define adder latency L = (REGISTER_MIDDLE!=0) + (REGISTER_OUTPUT!=0), range 0..2.
REQ-016 SHALL use a four-state FSM with states IDLE, ACCUM, WAIT and DONE.
REQ-017 In IDLE, with acc=0 and count=0, in_ready SHALL be 1; an accepted beat (in_valid&&in_ready) SHALL go to ACCUM.
REQ-018 An accepted beat SHALL drive adder operands acc and sign-extended in_data to ACC_BITS; count SHALL increment, saturating at MAX_LEN+1.
REQ-019 If L>0, the FSM SHALL enter WAIT for exactly L cycles with in_ready=0, then write the adder result (truncated to ACC_BITS) to acc.
REQ-020 If L=0, acc SHALL update on the acceptance edge and the block SHALL sustain one beat per cycle.
REQ-021 Throughput SHALL be one beat per L+1 cycles.
REQ-022 After a beat with in_last=1 commits, the FSM SHALL go to DONE; out_valid=1, out_data=acc, out_len=count and in_ready=0.
REQ-023 out_data, out_len and out_ovf SHALL be held stable while out_valid&&!out_ready.
REQ-024 On out_valid&&out_ready the FSM SHALL clear acc and count and return to IDLE; in_ready SHALL be 1 the next cycle (no bypass of DONE).
REQ-025 out_ovf SHALL be 1 when more than MAX_LEN beats were accepted in the reduction; the sum SHALL continue with wrap-around modulo 2^ACC_BITS.
REQ-026 A single-beat reduction (in_last on the first beat) SHALL output sign-extended in_data with out_len=1.
REQ-027 in_data and in_last SHALL be sampled only on acceptance; values while in_ready=0 SHALL be ignored.
REQ-028 Outputs SHALL be registered; there SHALL be no combinational path from in_valid or out_ready to any output except in_ready, which SHALL depend on state only.

Reset
REQ-029 While rst_n=0: state=IDLE, acc=0, count=0, out_valid=0, out_data=0, out_len=0, out_ovf=0 and in_ready=0; L-deep in-flight tracking SHALL be cleared.
REQ-030 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-031 Reset mid-reduction or in DONE SHALL discard all partial results with no output beat.
REQ-032 The adder node's active-high synchronous rst input SHALL be driven by ~rst_n; its contents SHALL be don't-care, since validity is tracked only by the FSM.

Structure
REQ-033 The shared package int_pkg SHALL hold the FSM state enum and a latency function f(REGISTER_MIDDLE, REGISTER_OUTPUT).
REQ-034 SHALL instantiate exactly one int_adder_tree_node with IN_BITS=ACC_BITS, OUT_BITS=ACC_BITS+1 and SIGN_EXT=1; its MSB SHALL be discarded.
REQ-035 WAIT timing SHALL use a down-counter of $clog2(L+1) bits; no other arithmetic units are permitted.

Verification
REQ-036 Bench SHALL cover, with L=1: beats 3, -5, 7 (last) -> out_data=5, out_len=3, out_ovf=0; in_ready low one cycle after each accept.
REQ-037 Bench SHALL cover, with L=0: 4 back-to-back beats of 32767 -> out_data=131068 and one accept per cycle.
REQ-038 Bench SHALL cover, with MAX_LEN=4: 5 beats of 1 -> out_len=5, out_ovf=1, out_data=5.
REQ-039 Bench SHALL cover out_ready held low 10 cycles in DONE -> outputs stable, in_ready=0 and no beat accepted.
REQ-040 Bench SHALL cover rst_n pulsed low after 2 of 4 beats -> no output; a fresh reduction of -1 (last) -> out_data=-1, out_len=1.
REQ-041 Bench SHALL cover, with L=2: random lengths 1..MAX_LEN and random valid/ready gaps -> every sum matches the reference model.
